// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - MIPS instruction fetch: PC, next-PC select, IF/ID register
// Optional misaligned-redirect flag: define IF_MISALIGN_CHECK_EN.
module instr_fetch_stage #(
  parameter int NUM_BITS_ADDR_BARRAMENTO = 32,
  parameter int NUM_BITS_MEM_PROG        = 32,
  parameter int NUM_BITS_ADDR_PROG       = 8,
  parameter logic [NUM_BITS_ADDR_BARRAMENTO-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                stall,
  input  logic                                branch_taken,
  input  logic [NUM_BITS_ADDR_BARRAMENTO-1:0] branch_target,
  input  logic                                jump,
  input  logic [NUM_BITS_ADDR_BARRAMENTO-1:0] jump_target,
  output logic [NUM_BITS_ADDR_BARRAMENTO-1:0] imem_addr,
  input  logic [NUM_BITS_MEM_PROG-1:0]        imem_rd,
  output logic [NUM_BITS_ADDR_BARRAMENTO-1:0] pc,
  output logic [NUM_BITS_MEM_PROG-1:0]        if_id_instr,
  output logic [NUM_BITS_ADDR_BARRAMENTO-1:0] if_id_pc4,
  output logic                                if_id_valid,
  output logic                                misalign_err
);

  localparam int AW = NUM_BITS_ADDR_BARRAMENTO;
  localparam logic [63:0] SPAN_MASK = (64'd1 << (NUM_BITS_ADDR_PROG + 2)) - 64'd1;
  // Word-aligned addresses inside program memory; also gives the wrap on +4.
  localparam logic [AW-1:0] PC_MASK = AW'(SPAN_MASK) & ~AW'(3);
  localparam logic [AW-1:0] PC_STEP = AW'(4);

  logic          redirect;
  logic [AW-1:0] raw_target;
  logic [AW-1:0] seq_pc;

  always_comb begin
    redirect   = branch_taken | jump;
    raw_target = branch_taken ? branch_target : jump_target;
    seq_pc     = (pc + PC_STEP) & PC_MASK;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC & PC_MASK;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      // Redirect beats stall so the flush is never lost.
      pc          <= raw_target & PC_MASK;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= seq_pc;
      if_id_instr <= imem_rd;
      if_id_pc4   <= seq_pc;
      if_id_valid <= 1'b1;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (redirect && (raw_target[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch stage of the MIPS core: owns the program counter and drives the address of the combinational instruction memory. It captures the returned word into the IF/ID pipeline register, together with PC+4 and a valid bit. It computes the next PC with priority between a branch redirect, a jump redirect, a pipeline stall and sequential advance.

## Interface
Parameters:
- NUM_BITS_ADDR_BARRAMENTO, 32, address bus width (PC width); fixed by the 32-bit architecture.
- NUM_BITS_MEM_PROG, 32, instruction word width; fixed by the architecture.
- NUM_BITS_ADDR_PROG, 8, word-address bits of program memory; must equal the value used by instruction memory.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID contents (hazard unit).
- branch_taken  in  1  redirect to branch_target (resolved in a later stage).
- branch_target  in  NUM_BITS_ADDR_BARRAMENTO  branch destination byte address.
- jump  in  1  redirect to jump_target.
- jump_target  in  NUM_BITS_ADDR_BARRAMENTO  jump destination byte address.
- imem_addr  out  NUM_BITS_ADDR_BARRAMENTO  byte address to instruction memory (= pc).
- imem_rd  in  NUM_BITS_MEM_PROG  instruction word returned combinationally.
- pc  out  NUM_BITS_ADDR_BARRAMENTO  current PC.
- if_id_instr  out  NUM_BITS_MEM_PROG  registered instruction.
- if_id_pc4  out  NUM_BITS_ADDR_BARRAMENTO  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- misalign_err  out  1  sticky misaligned-target flag (only with IF_MISALIGN_CHECK_EN; otherwise tied 0).

## Operation
- PC space: byte address; bits [1:0] always 0. Bits above NUM_BITS_ADDR_PROG+1 are always 0. Sequential increment wraps from the last word (4*2^NUM_BITS_ADDR_PROG − 4, i.e. 0x3FC by default) to 0.
- Targets are masked to the same range: bits [1:0] cleared, upper bits cleared.
- imem_addr = pc, combinationally.
- Next-state priority per rising edge, highest first:
  - reset: pc=RESET_PC (masked), if_id_instr=0 (NOP), if_id_pc4=0, if_id_valid=0, misalign_err=0.
  - branch_taken: pc=branch_target, if_id_valid=0, if_id_instr=0. The branch is older than the jump, so it wins when both are asserted.
  - jump: pc=jump_target, if_id_valid=0, if_id_instr=0.
  - stall: pc, if_id_* unchanged.
  - else: if_id_instr=imem_rd, if_id_pc4=pc+4 (wrapped), if_id_valid=1, pc=pc+4 (wrapped).
- A redirect overrides a simultaneous stall, so the flush always takes effect.
- if_id_pc4 is computed with the same wrap as pc.

## Timing
- Fetch latency: instruction at pc appears on if_id_instr one clock after pc is presented.
- After rst_n deassertion: first edge captures word at RESET_PC, sets valid=1, pc=RESET_PC+4.
- Redirect penalty: one bubble. On the edge with the redirect, IF/ID becomes invalid. On the next edge the target instruction is captured.
- rst_n assertion mid-operation clears all state immediately, without waiting for clk. Deassertion is expected synchronous to clk, which is a system-level requirement.
- Stall held N cycles freezes all outputs for N edges. Sequential advance resumes on the first edge with stall=0.

## Configuration
- IF_MISALIGN_CHECK_EN defined: the check applies to a redirect whose selected target has bits [1:0] ≠ 0.
  - The redirect is still taken with the target masked.
  - misalign_err is set and stays set until reset.
- IF_MISALIGN_CHECK_EN undefined: targets are silently masked; misalign_err is constant 0 and the flag register is not built.

## Test plan
- Reset then free-run with imem_rd = address-derived word: pc steps 0,4,8,…; if_id_pc4 = pc of the captured word + 4; valid=1 from the first edge.
- Wrap: run to pc=0x3FC → next edge pc=0x000 and if_id_pc4=0x000.
- Stall for 3 cycles at pc=0x010 → pc, if_id_instr and if_id_valid unchanged for 3 edges, then pc=0x014.
- branch_taken=1 (target 0x040) and jump=1 (target 0x080) with stall=1, same cycle → pc=0x040 and valid=0. Next edge captures word 0x040 with valid=1.
- Assert rst_n low asynchronously between edges at pc=0x020 → pc=0 and valid=0 immediately, without a clock edge.
- With IF_MISALIGN_CHECK_EN, jump to 0x023 → pc=0x020 and misalign_err=1, held through subsequent redirects until reset. Without the macro, the same stimulus gives pc=0x020 and misalign_err=0.
